vga_sync_rx: RTL and testbench

- Receive side of the 640x480@60 VGA link: samples incoming active-low hsync/vsync and 4-bit-per-channel RGB on a pixel-enable strobe.
- Measures line and frame lengths and locks onto a valid timing.
- Once locked, regenerates active-area pixel coordinates, data-enable and registered colour for downstream capture/compare logic.
- Sits behind the pixel clock enable in the single system clock domain.

---
 rtl/vga_sync_rx.sv | 133 +++++++++++++
 tb/tb_vga_sync_rx.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/vga_sync_rx.sv
// vga_sync_rx: measures VGA line/frame timing, locks onto it and regenerates active-area coordinates, de and colour.
module vga_sync_rx #(
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int H_ACT       = 640,
  parameter int H_TOTAL     = 800,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int V_ACT       = 480,
  parameter int V_TOTAL     = 525,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [3:0] r_in,
  input  logic [3:0] g_in,
  input  logic [3:0] b_in,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       de,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       frame_start,
  output logic       locked,
  output logic       timing_err,
  output logic [9:0] h_meas,
  output logic [9:0] v_meas
);
  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;
  localparam logic [9:0] HS = 10'(H_SYNC + H_BP);
  localparam logic [9:0] HE = 10'(H_SYNC + H_BP + H_ACT);
  localparam logic [9:0] VS = 10'(V_SYNC + V_BP);
  localparam logic [9:0] VE = 10'(V_SYNC + V_BP + V_ACT);
  state_t      state_q, state_d;
  logic        hs_q, vs_line_q, seen_h_q, seen_v_q, frame_bad_q, frame_bad_d;
  logic [7:0]  good_q, good_d;
  logic [9:0]  hcnt_q, vcnt_q, h_meas_q, v_meas_q, x_q, y_q;
  logic [11:0] rgb_q, col_q;
  logic        de_q, frame_start_q, timing_err_q;
  logic        hfall, vfall, tmo, err, clean, in_h, in_v, de_d;
  logic [10:0] h_len, v_len;
  assign hfall = !hsync && hs_q;
  assign vfall = hfall && !vsync && vs_line_q;
  assign h_len = {1'b0, hcnt_q} + 11'd1;
  assign v_len = {1'b0, vcnt_q} + 11'd1;
  // Timeout fires once, on the tick the pixel counter saturates.
  assign tmo   = !hfall && hcnt_q == 10'd1022;
  assign err   = tmo || (hfall && seen_h_q && h_len != 11'(H_TOTAL))
               || (vfall && seen_v_q && v_len != 11'(V_TOTAL));
  assign clean = !frame_bad_q && !err;
  assign in_h  = hcnt_q >= HS && hcnt_q < HE;
  assign in_v  = vcnt_q >= VS && vcnt_q < VE;
  assign de_d  = state_q == LOCKED && in_h && in_v;
  always_comb begin
    state_d     = state_q;
    good_d      = good_q;
    frame_bad_d = frame_bad_q;
    if (state_q == SEARCH) begin
      if (vfall) begin
        state_d     = TRACK;
        good_d      = 8'd0;
        frame_bad_d = 1'b0;
      end
    end else if (state_q == TRACK) begin
      if (tmo) state_d = SEARCH;
      else if (vfall) begin
        frame_bad_d = 1'b0;
        good_d      = clean ? good_q + 8'd1 : 8'd0;
        state_d     = (clean && good_q + 8'd1 == 8'(LOCK_FRAMES)) ? LOCKED : TRACK;
      end else if (err) frame_bad_d = 1'b1;
    end else if (err) state_d = SEARCH;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= SEARCH;
      hs_q          <= 1'b1;
      vs_line_q     <= 1'b1;
      seen_h_q      <= 1'b0;
      seen_v_q      <= 1'b0;
      frame_bad_q   <= 1'b0;
      good_q        <= 8'd0;
      hcnt_q        <= 10'd0;
      vcnt_q        <= 10'd0;
      h_meas_q      <= 10'd0;
      v_meas_q      <= 10'd0;
      rgb_q         <= 12'd0;
      col_q         <= 12'd0;
      x_q           <= 10'd0;
      y_q           <= 10'd0;
      de_q          <= 1'b0;
      frame_start_q <= 1'b0;
      timing_err_q  <= 1'b0;
    end else begin
      frame_start_q <= pix_en && vfall;
      timing_err_q  <= pix_en && err && state_q != SEARCH;
      if (pix_en) begin
        hs_q        <= hsync;
        rgb_q       <= {r_in, g_in, b_in};
        hcnt_q      <= hfall ? 10'd0 : (&hcnt_q ? hcnt_q : hcnt_q + 10'd1);
        state_q     <= state_d;
        good_q      <= good_d;
        frame_bad_q <= frame_bad_d;
        de_q        <= de_d;
        x_q         <= de_d ? hcnt_q - HS : 10'd0;
        y_q         <= de_d ? vcnt_q - VS : 10'd0;
        col_q       <= de_d ? rgb_q : 12'd0;
        if (hfall) begin
          h_meas_q  <= h_len[9:0];
          vs_line_q <= vsync;
          seen_h_q  <= 1'b1;
          vcnt_q    <= vfall ? 10'd0 : (&vcnt_q ? vcnt_q : vcnt_q + 10'd1);
        end
        if (vfall) begin
          v_meas_q <= v_len[9:0];
          seen_v_q <= 1'b1;
        end
      end
    end
  end
  assign x                  = x_q;
  assign y                  = y_q;
  assign de                 = de_q;
  assign {red, green, blue} = col_q;
  assign frame_start        = frame_start_q;
  assign locked             = state_q == LOCKED;
  assign timing_err         = timing_err_q;
  assign h_meas             = h_meas_q;
  assign v_meas             = v_meas_q;
endmodule

// File: tb/tb_vga_sync_rx.sv
// tb_vga_sync_rx: directed bench on a scaled 16x8 timing (active 8x4 at offset 4,3).
module tb_vga_sync_rx;
  localparam int HT = 16, VT = 8, HSY = 2, VSY = 1;
  logic clk = 0, rst = 1, pix_en = 0, hsync = 1, vsync = 1;
  logic [3:0] r_in = 0, g_in = 0, b_in = 0, red, green, blue;
  logic [9:0] x, y, h_meas, v_meas;
  logic de, frame_start, locked, timing_err;
  int checks = 0, failures = 0, te_cnt = 0, fs_cnt = 0;
  int hp = 0, vl = 0, hlen = HT, vlen = VT;
  logic ovr = 0, hold = 0;
  vga_sync_rx #(.H_SYNC(2), .H_BP(2), .H_ACT(8), .H_TOTAL(HT), .V_SYNC(1), .V_BP(2),
    .V_ACT(4), .V_TOTAL(VT), .LOCK_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .x(x), .y(y), .de(de),
    .red(red), .green(green), .blue(blue), .frame_start(frame_start),
    .locked(locked), .timing_err(timing_err), .h_meas(h_meas), .v_meas(v_meas));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    pix_en = 1;
    hsync  = hold ? 1'b1 : (hp < HSY ? 1'b0 : 1'b1);
    vsync  = vl < VSY ? 1'b0 : 1'b1;
    r_in   = ovr ? 4'hF : 4'(hp);
    g_in   = ovr ? 4'h0 : 4'(vl);
    b_in   = ovr ? 4'h0 : ~4'(hp);
    @(posedge clk); #1;
    te_cnt += int'(timing_err);
    fs_cnt += int'(frame_start);
    hp++;
    if (hp >= hlen) begin
      hp = 0;
      vl++;
      if (vl >= vlen) vl = 0;
    end
  endtask
  task automatic run_to(input int h, input int v);
    while (!(hp == h && vl == v)) step();
  endtask
  task automatic stall(input int n);
    pix_en = 0;
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_all", {x, y, de, red, green, blue, frame_start, locked, timing_err, h_meas, v_meas}, 64'd0);
    rst = 0;
    repeat (256) step();
    chk("no_lock_2nd_vfall", locked, 1'b0);
    chk("fs_count_2", fs_cnt, 2);
    step();
    chk("lock_3rd_vfall", locked, 1'b1);
    chk("frame_start_pulse", frame_start, 1'b1);
    chk("h_meas", h_meas, 10'd16);
    chk("v_meas", v_meas, 10'd8);
    chk("no_timing_err", te_cnt, 0);
    run_to(4, 3);
    ovr = 1;
    step();
    ovr = 0;
    step();
    chk("first_px", {de, x, y, red, green, blue}, {1'b1, 10'd0, 10'd0, 12'hF00});
    stall(3);
    chk("stall_hold", {de, x, red, frame_start, timing_err}, {1'b1, 10'd0, 4'hF, 2'b00});
    step();
    chk("after_stall", {x, red}, {10'd1, 4'h5});
    run_to(11, 3);
    step();
    step();
    chk("last_px", {de, x, y, red, green, blue}, {1'b1, 10'd7, 10'd0, 12'hB34});
    step();
    chk("right_porch", {de, x, y, red, green, blue}, 35'd0);
    run_to(4, 6);
    step();
    step();
    chk("last_row", {de, x, y}, {1'b1, 10'd0, 10'd3});
    run_to(4, 7);
    step();
    step();
    chk("bottom_porch", {de, y}, 11'd0);
    run_to(0, 2);
    te_cnt = 0;
    hlen = HT - 1;
    run_to(0, 3);
    hlen = HT;
    step();
    chk("short_line_err", {timing_err, locked}, 2'b10);
    chk("short_line_meas", h_meas, 10'd15);
    step();
    chk("err_one_clk", timing_err, 1'b0);
    run_to(0, 0);
    step();
    chk("relock_track", locked, 1'b0);
    run_to(0, 0);
    step();
    chk("relock_good1", locked, 1'b0);
    run_to(0, 0);
    step();
    chk("relocked", locked, 1'b1);
    chk("single_err_pulse", te_cnt, 1);
    run_to(5, 3);
    hold = 1;
    step();
    repeat (1017) step();
    chk("pre_timeout", {timing_err, locked}, 2'b01);
    step();
    chk("timeout", {timing_err, locked, de}, 3'b100);
    step();
    chk("timeout_one_clk", timing_err, 1'b0);
    hold = 0;
    run_to(0, 0);
    step();
    chk("track_after_tmo", {locked, timing_err}, 2'b00);
    run_to(0, 0);
    step();
    chk("track_good1", {locked, timing_err}, 2'b00);
    vlen = VT - 1;
    run_to(0, 0);
    vlen = VT;
    step();
    chk("short_frame_err", {timing_err, locked}, 2'b10);
    chk("short_frame_meas", v_meas, 10'd7);
    run_to(0, 0);
    step();
    chk("short_frame_reset_good", {locked, timing_err}, 2'b00);
    run_to(0, 0);
    step();
    chk("relock_after_short", locked, 1'b1);
    run_to(6, 4);
    step();
    step();
    chk("mid_line_active", {de, x, y}, {1'b1, 10'd2, 10'd1});
    rst = 1;
    #1;
    chk("async_reset", {x, y, de, red, green, blue, frame_start, locked, timing_err, h_meas, v_meas}, 64'd0);
    @(posedge clk);
    #1;
    rst = 0;
    run_to(0, 0);
    step();
    chk("post_rst_vfall1", locked, 1'b0);
    run_to(0, 0);
    step();
    chk("post_rst_vfall2", locked, 1'b0);
    run_to(0, 0);
    step();
    chk("post_rst_lock", locked, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
